// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end. Issues word-aligned reads to a ROM with a fixed
// one-cycle read latency, buffers the returned words in a small show-ahead FIFO
// tagged with their addresses, and presents the FIFO head to the core through
// a valid/ready handshake. A taken branch/jump (redirect) flushes the buffer,
// drops the response currently in flight and restarts fetching at the target.
//
// Optional feature (compile-time macro IFU_MISALIGN_CHECK_EN):
//   defined   - a redirect to a non word-aligned target is a fault: the buffer
//               is flushed, fetch_fault is set and the unit parks in FAULT
//               (no further ROM requests) until reset.
//   undefined - the two low target bits are ignored and fetch_fault stays 0.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer depth, power of 2 from 2 to 8
//
// Ports
//   clk_out         in   CPU clock, rising-edge active
//   rst             in   asynchronous, active-high reset
//   rom_en          out  ROM read request this cycle
//   rom_addr[11:0]  out  ROM byte address (current fetch pc)
//   rom_data[31:0]  in   ROM read data, valid one cycle after rom_en
//   inst_valid      out  inst/inst_pc hold a valid instruction
//   inst_ready      in   core accepts inst when inst_valid is also high
//   inst[31:0]      out  instruction at the FIFO head
//   inst_pc[11:0]   out  address of inst
//   redirect_valid  in   taken branch / JAL / JALR
//   redirect_pc     in   redirect target address
//   fetch_fault     out  sticky misaligned-target flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [11:0] RESET_PC   = 12'h000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_out,
  input  logic        rst,
  output logic        rom_en,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [11:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [11:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic MISALIGN_CHECK = 1'b1;
`else
  localparam logic MISALIGN_CHECK = 1'b0;
`endif

  // State
  logic [0:0]       state_r;
  logic [0:0]       next_state_s;
  logic             fault_r;
  logic [11:0]      fetch_pc_r;
  logic             inflight_r;
  logic [11:0]      inflight_pc_r;
  logic [31:0]      fifo_data_r [FIFO_DEPTH];
  logic [11:0]      fifo_pc_r   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Decoded control
  logic             redirect_take_s;
  logic             misalign_s;
  logic             fault_enter_s;
  logic             flush_s;
  logic [11:0]      target_pc_s;
  logic [CNT_W-1:0] occupied_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  logic             head_valid_s;

  // Redirect decode: redirects are honoured only in RUN; in FAULT they are ignored.
  always_comb begin
    redirect_take_s = redirect_valid && (state_r == ST_RUN);
    misalign_s      = (redirect_pc[1:0] != 2'b00);
`ifdef IFU_MISALIGN_CHECK_EN
    target_pc_s     = redirect_pc;
`else
    target_pc_s     = {redirect_pc[11:2], 2'b00};
`endif
    fault_enter_s   = MISALIGN_CHECK && redirect_take_s && misalign_s;
    // Both a normal redirect and a misalignment fault empty the buffer.
    flush_s         = redirect_take_s;
  end

  // Request credit and FIFO push/pop qualification.
  always_comb begin
    head_valid_s = (count_r != {CNT_W{1'b0}});
    // Buffered entries plus the response still on its way; the credit check
    // guarantees every issued request has a free slot when it returns.
    occupied_s   = count_r + CNT_W'(inflight_r);
    if (!rst && (state_r == ST_RUN) && !redirect_valid && (occupied_s < DEPTH_CNT)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    // A flush wins over a simultaneous push and pop; the pop is still a
    // consumed instruction from the core's point of view.
    push_s = inflight_r && !flush_s;
    pop_s  = head_valid_s && inst_ready && !flush_s;
  end

  // Next run/fault state; FAULT is only left through reset.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (fault_enter_s) begin
          next_state_s = ST_FAULT;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FAULT: next_state_s = ST_FAULT;
      default:  next_state_s = ST_RUN;
    endcase
  end

  // State register and sticky fault flag.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      fault_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      fault_r <= fault_r || fault_enter_s;
    end
  end

  // Fetch pc: reload on an accepted aligned redirect, otherwise step per request.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
    end else if (flush_s && !fault_enter_s) begin
      fetch_pc_r <= target_pc_s;
    end else if (issue_s) begin
      fetch_pc_r <= fetch_pc_r + 12'd4;  // 12-bit add wraps FFC -> 000
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // In-flight tracker: remembers the address of the request whose data arrives
  // next cycle. A flush clears it, which kills that response (push_s is also
  // gated on the flush edge, so the word that arrives then is dropped).
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      inflight_r    <= 1'b0;
      inflight_pc_r <= 12'h000;
    end else begin
      inflight_r <= issue_s && !flush_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
      end else begin
        inflight_pc_r <= inflight_pc_r;
      end
    end
  end

  // Instruction FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      // Storage is cleared so the head outputs read zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= 32'h0000_0000;
        fifo_pc_r[i]   <= 12'h000;
      end
    end else if (flush_s) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= rom_data;
        fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rom_en      = issue_s;
  assign rom_addr    = fetch_pc_r;
  assign inst_valid  = head_valid_s;
  assign inst        = fifo_data_r[rd_ptr_r];
  assign inst_pc     = fifo_pc_r[rd_ptr_r];
  assign fetch_fault = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. The ROM returns word (addr >> 2)
// one cycle after a request and random garbage otherwise. A transaction-level
// model tracks buffer occupancy, the expected fetch address and the expected
// in-order instruction stream; every cycle the DUT outputs are compared to it.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [11:0] RPC   = 12'h000;

`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk_out;
  logic        rst;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [11:0] inst_pc;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          occ_m;
  bit          infl_m;
  bit          fault_m;
  logic [11:0] exp_fetch;
  logic [11:0] exp_pc;

  // Observations of the current cycle
  bit          ren_q;
  logic [11:0] raddr_q;
  bit          valid_q;
  bit          acc_flag;
  logic [11:0] acc_pc;
  logic [31:0] acc_inst;
  logic [11:0] last_issued;
  int          wrap_seen;
  int          en_count;

  instr_fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_out        (clk_out),
    .rst            (rst),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  function automatic logic [31:0] word(input logic [11:0] a);
    return {22'd0, a[11:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check at mid-cycle,
  // advance the model across the coming edge, then play the ROM response.
  task automatic tick(input bit ready, input bit rv, input logic [11:0] rpc);
    bit          exp_en;
    bit          exp_valid;
    bit          take;
    bit          mis;
    bit          acc;
    logic [11:0] tgt;
    inst_ready     = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #4;
    acc_flag = 1'b0;
    ren_q    = rom_en;
    raddr_q  = rom_addr;
    valid_q  = inst_valid;
    if (rst) begin
      check("rst_rom_en", 32'(rom_en), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", 32'(inst_pc), 32'd0);
      check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    end else begin
      tgt       = MIS_EN ? rpc : {rpc[11:2], 2'b00};
      take      = rv && !fault_m;
      mis       = MIS_EN && take && (rpc[1:0] != 2'b00);
      exp_en    = !fault_m && !rv && ((occ_m + int'(infl_m)) < DEPTH);
      exp_valid = (occ_m != 0);
      check("rom_en", 32'(rom_en), 32'(exp_en));
      if (rom_en && exp_en) check("rom_addr", 32'(rom_addr), 32'(exp_fetch));
      check("inst_valid", 32'(inst_valid), 32'(exp_valid));
      check("fetch_fault", 32'(fetch_fault), 32'(fault_m));
      if (exp_valid) begin
        check("inst_pc", 32'(inst_pc), 32'(exp_pc));
        check("inst", inst, word(exp_pc));
      end
      if (rom_en) begin
        en_count++;
        if (last_issued == 12'hFFC) begin
          check("wrap_addr", 32'(rom_addr), 32'h000);
          wrap_seen++;
        end
        last_issued = rom_addr;
      end
      if (inst_valid && ready) begin
        acc_flag = 1'b1;
        acc_pc   = inst_pc;
        acc_inst = inst;
      end
      acc = exp_valid && ready;
      if (acc) exp_pc = exp_pc + 12'd4;
      if (take) begin
        occ_m       = 0;
        infl_m      = 1'b0;
        last_issued = 12'h001;
        if (mis) begin
          fault_m = 1'b1;
        end else begin
          exp_fetch = tgt;
          exp_pc    = tgt;
        end
      end else begin
        occ_m  = occ_m + int'(infl_m) - int'(acc);
        infl_m = exp_en;
        if (exp_en) exp_fetch = exp_fetch + 12'd4;
      end
    end
    @(posedge clk_out);
    #1;
    rom_data = ren_q ? word(raddr_q) : $urandom;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 12'h000);
    rst         = 1'b0;
    occ_m       = 0;
    infl_m      = 1'b0;
    fault_m     = 1'b0;
    exp_fetch   = RPC;
    exp_pc      = RPC;
    last_issued = 12'h001;
  endtask

  initial begin
    int          first_en;
    int          first_val;
    int          n_acc;
    logic [11:0] a_pc   [3];
    logic [31:0] a_inst [3];
    bit          found;

    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 12'h000;
    rom_data       = 32'd0;
    last_issued    = 12'h001;
    wrap_seen      = 0;
    en_count       = 0;
    @(posedge clk_out);
    #1;

    // Reset release with the core always ready.
    reset_dut();
    first_en  = -1;
    first_val = -1;
    n_acc     = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 12'h000);
      if (first_en < 0 && ren_q) first_en = i;
      if (first_val < 0 && valid_q) first_val = i;
      if (acc_flag && n_acc < 3) begin
        a_pc[n_acc]   = acc_pc;
        a_inst[n_acc] = acc_inst;
        n_acc++;
      end
    end
    check("a_first_en_cycle", 32'(first_en), 32'd0);
    check("a_latency", 32'(first_val - first_en), 32'd2);
    check("a_accept_count", 32'(n_acc), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < n_acc) begin
        check("a_pair_pc", 32'(a_pc[k]), 32'(4 * k));
        check("a_pair_inst", a_inst[k], 32'(k));
      end
    end

    // Core stalled for 10 cycles: buffer fills, fetching stops, head holds.
    reset_dut();
    en_count = 0;
    repeat (10) tick(1'b0, 1'b0, 12'h000);
    check("b_fill_requests", 32'(en_count), 32'(DEPTH));
    check("b_head_valid", 32'(inst_valid), 32'd1);
    check("b_head_pc", 32'(inst_pc), 32'h000);
    repeat (20) tick(1'b1, 1'b0, 12'h000);

    // Redirect while a response is in flight.
    for (int i = 0; i < 20 && !infl_m; i++) tick(($urandom_range(0, 1) != 0), 1'b0, 12'h000);
    check("c_inflight", 32'(infl_m), 32'd1);
    tick(1'b1, 1'b1, 12'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, 12'h000);
      if (acc_flag) begin
        found = 1'b1;
        check("c_next_pc", 32'(acc_pc), 32'h100);
      end
    end
    check("c_accept_seen", 32'(found), 32'd1);

    // Fetch pc wrap from FFC to 000.
    tick(1'b1, 1'b1, 12'hFF8);
    wrap_seen = 0;
    repeat (12) tick(1'b1, 1'b0, 12'h000);
    check("d_wrap_seen", 32'(wrap_seen != 0), 32'd1);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] r;
      r = 12'($urandom);
      if (MIS_EN) r[1:0] = 2'b00;
      tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), r);
    end

    // Misaligned redirect target.
    tick(1'b1, 1'b1, 12'h102);
`ifdef IFU_MISALIGN_CHECK_EN
    en_count = 0;
    repeat (8) tick(($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0), 12'h200);
    check("f_fault_flag", 32'(fetch_fault), 32'd1);
    check("f_no_fetch", 32'(en_count), 32'd0);
    reset_dut();
    repeat (4) tick(1'b1, 1'b0, 12'h000);
    check("f_fault_cleared", 32'(fetch_fault), 32'd0);
`else
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, 12'h000);
      if (acc_flag) begin
        found = 1'b1;
        check("f_masked_pc", 32'(acc_pc), 32'h100);
      end
    end
    check("f_accept_seen", 32'(found), 32'd1);
    check("f_no_fault", 32'(fetch_fault), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
